mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between the instruction-fetch requester and the data (load/store) requester of the multi-cycle RV64 core.
- Sits between the control unit / datapath and the memory model.
- Serialises one access at a time with fixed memory latency and round-robin grant.
- Returns read data with a one-cycle ack pulse per transaction.

Parameters:
- WORDSIZE, 64, data width of all data buses.
- ADDR_WIDTH, 64, address width.
- MEM_LATENCY, 2, cycles from the memory command cycle to valid mem_rdata; legal range is 1 and above.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_ack.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  WORDSIZE  fetched word; valid in the if_ack cycle and held afterwards.
- dm_req  in  1  data request; held with dm_we, dm_addr and dm_wdata until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_WIDTH  data address.
- dm_wdata  in  WORDSIZE  store data.
- dm_ack  out  1  one-cycle completion pulse for data.
- dm_rdata  out  WORDSIZE  load result; updated on loads only.
- mem_en  out  1  one-cycle memory command strobe.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  WORDSIZE  memory write data.
- mem_rdata  in  WORDSIZE  memory read data; valid MEM_LATENCY cycles after the mem_en cycle.
- busy  out  1  high whenever state is not IDLE.
- grant  out  1  current owner, 0 = fetch, 1 = data; meaningful while busy.

Behaviour:
- Reset: rst_n low asynchronously forces:
  - state IDLE;
  - all outputs 0, including both rdata registers and mem_* buses;
  - latency counter 0;
  - last_grant 1, so fetch wins the first tie.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If no request, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - On the granting edge:
    - latch the owner's addr, wdata and we (fetch forces we = 0);
    - set grant and last_grant;
    - load counter = MEM_LATENCY;
    - go to ACCESS.
- ACCESS:
  - First cycle: mem_en = 1; mem_we, mem_addr and mem_wdata driven from the latched values.
  - Remaining cycles: mem_en = 0; mem_addr, mem_we and mem_wdata hold their values throughout ACCESS.
  - Counter decrements each cycle.
  - In the cycle the counter reaches 0 (cycle mem_en + MEM_LATENCY), that edge:
    - captures mem_rdata into the owner's rdata register, for reads only;
    - goes to RESP.
- RESP:
  - The owner's ack is high for exactly one cycle; the other ack is 0.
  - mem_we is 0.
  - Next state is always IDLE.
- Timing:
  - Request sampled in IDLE cycle R → mem_en in R+1 → ack in R+2+MEM_LATENCY → IDLE in R+3+MEM_LATENCY.
  - Transaction period is MEM_LATENCY+3 cycles.
- Handshake rules:
  - A requester that wants no further access drops req on the edge ending its ack cycle.
  - req still high in the following IDLE cycle is a new request; back-to-back requests are legal.
  - req dropping mid-transaction is ignored: the transaction completes and ack still pulses.
  - Input changes after the granting edge do not affect the transaction in flight.
- Round-robin: with both requests held continuously, grants alternate strictly, so neither requester starves.
- Stores: dm_rdata is left unchanged; dm_ack timing is identical to loads.
- Addresses and data pass through unmodified; no alignment checking.
- Reset mid-operation: the transaction in flight is dropped with no ack. After release, arbitration restarts from IDLE with last_grant = 1.
- No X on outputs after reset. The counter is wide enough to hold MEM_LATENCY.

Test Plan:
- Single fetch, MEM_LATENCY 2: if_req = 1 with if_addr 0x100 in cycle R; the model returns 0xDEADBEEF00000013.
  - Required: mem_en = 1, mem_we = 0, mem_addr 0x100 in R+1.
  - Required: if_ack = 1 in R+4 with if_rdata 0xDEADBEEF00000013; dm_ack = 0 throughout; busy high R+1..R+4.
- Single store: dm_we = 1, dm_addr 0x2008, dm_wdata 0x1234 in cycle R.
  - Required: mem_en = 1, mem_we = 1, mem_wdata 0x1234 in R+1.
  - Required: dm_ack in R+4; dm_rdata unchanged from its prior value.
- Simultaneous requests after reset, both raised in cycle R:
  - Required: grant = 0 and if_ack in R+4.
  - Required: data mem_en in R+6, dm_ack in R+9, grant = 1 during R+6..R+9.
- Both requests held for 6 transactions:
  - Required: grant sequence 0,1,0,1,0,1.
  - Required: ack pulses spaced 5 cycles apart; never two acks in one cycle.
- rst_n low in R+2 of a fetch:
  - Required: immediately, mem_en/busy/if_ack = 0 and if_rdata = 0; no ack after release.
  - Required: if_req still high is re-served from IDLE with full latency.
- Instance with MEM_LATENCY 1, load from 0x40 returning 0x55:
  - Required: mem_en in R+1, dm_ack in R+3 with dm_rdata 0x55.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int WORDSIZE   = 64,
  parameter int ADDR_WIDTH = 64
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ack;
  logic [WORDSIZE-1:0]   if_rdata;
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [WORDSIZE-1:0]   dm_wdata;
  logic                  dm_ack;
  logic [WORDSIZE-1:0]   dm_rdata;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORDSIZE-1:0]   mem_wdata;
  logic [WORDSIZE-1:0]   mem_rdata;
  logic                  busy;
  logic                  grant;

  modport slave (
    input  if_req,
    input  if_addr,
    input  dm_req,
    input  dm_we,
    input  dm_addr,
    input  dm_wdata,
    input  mem_rdata,
    output if_ack,
    output if_rdata,
    output dm_ack,
    output dm_rdata,
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output busy,
    output grant
  );

  modport master (
    output if_req,
    output if_addr,
    output dm_req,
    output dm_we,
    output dm_addr,
    output dm_wdata,
    output mem_rdata,
    input  if_ack,
    input  if_rdata,
    input  dm_ack,
    input  dm_rdata,
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  busy,
    input  grant
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port
// between instruction fetch and load/store.
module mem_port_arbiter #(
  parameter int WORDSIZE    = 64,
  parameter int ADDR_WIDTH  = 64,
  parameter int MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          pick;
  logic          any_req;

  assign any_req  = bus.if_req | bus.dm_req;
  assign bus.busy = (state != IDLE);

  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      bus.if_req && bus.dm_req: pick = ~last_grant;
      !bus.if_req && bus.dm_req: pick = 1'b1;
      default: pick = 1'b0;
    endcase
  end

  // mem_* registers double as the latched request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= 1'b1;
      bus.grant     <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_ack    <= 1'b0;
      bus.dm_ack    <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
    end else begin
      bus.mem_en <= 1'b0;
      bus.if_ack <= 1'b0;
      bus.dm_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state         <= ACCESS;
            bus.grant     <= pick;
            last_grant    <= pick;
            cnt           <= CW'(MEM_LATENCY);
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= pick & bus.dm_we;
            bus.mem_addr  <= pick ? bus.dm_addr
                                  : bus.if_addr;
            bus.mem_wdata <= pick ? bus.dm_wdata
                                  : '0;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state      <= RESP;
            bus.mem_we <= 1'b0;
            bus.if_ack <= ~bus.grant;
            bus.dm_ack <= bus.grant;
            if (!bus.mem_we) begin
              if (bus.grant)
                bus.dm_rdata <= bus.mem_rdata;
              else
                bus.if_rdata <= bus.mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter
// against a transaction-offset reference model.
module tb_mem_port_arbiter;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.WORDSIZE(64), .ADDR_WIDTH(64)) b ();
  mem_port_arbiter_if #(.WORDSIZE(64), .ADDR_WIDTH(64)) b2 ();

  mem_port_arbiter #(
    .WORDSIZE(64), .ADDR_WIDTH(64), .MEM_LATENCY(L)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(b));

  mem_port_arbiter #(
    .WORDSIZE(64), .ADDR_WIDTH(64), .MEM_LATENCY(1)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(b2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h",
               name, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  logic [63:0] mem [logic [63:0]];

  function automatic logic [63:0] rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 64'h9E3779B97F4A7C15) ^ 64'h0123456789ABCDEF;
  endfunction

  // memory environment: data appears exactly L cycles after mem_en
  logic [63:0] ret;
  int ret_cyc = -100;
  initial begin
    b.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (b.mem_en) begin
        if (b.mem_we) mem[b.mem_addr] = b.mem_wdata;
        else begin
          ret = rd(b.mem_addr);
          ret_cyc = cyc + L;
        end
      end
      b.mem_rdata = (cyc == ret_cyc) ? ret : {$urandom, $urandom};
    end
  end

  logic [63:0] ret2;
  int ret2_cyc = -100;
  initial begin
    b2.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (b2.mem_en && !b2.mem_we) begin
        ret2 = (b2.mem_addr == 64'h40) ? 64'h55 : ~b2.mem_addr;
        ret2_cyc = cyc + 1;
      end
      b2.mem_rdata = (cyc == ret2_cyc) ? ret2 : {$urandom, $urandom};
    end
  end

  // reference model: position k inside the current transaction
  bit m_act = 0;
  int m_k = 0;
  bit m_own = 0;
  bit m_last = 1;
  bit m_we = 0;
  logic [63:0] m_addr = '0, m_wd = '0, m_rd = '0;
  logic [63:0] m_ifr = '0, m_dmr = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_act = 0; m_k = 0; m_own = 0; m_last = 1;
      m_we = 0; m_ifr = '0; m_dmr = '0;
    end else if (!m_act) begin
      if (b.if_req || b.dm_req) begin
        m_own = (b.if_req && b.dm_req) ? !m_last : b.dm_req;
        m_last = m_own;
        m_we = m_own && b.dm_we;
        m_addr = m_own ? b.dm_addr : b.if_addr;
        m_wd = b.dm_wdata;
        m_rd = rd(m_addr);
        m_act = 1;
        m_k = 1;
      end
    end else begin
      m_k++;
      if (m_k == L + 2 && !m_we) begin
        if (m_own) m_dmr = m_rd;
        else m_ifr = m_rd;
      end
      if (m_k == L + 3) begin
        m_act = 0;
        m_k = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("busy", b.busy, m_act);
    chk("mem_en", b.mem_en, m_act && m_k == 1);
    chk("mem_we", b.mem_we, m_act && m_k <= L + 1 && m_we);
    chk("if_ack", b.if_ack, m_act && m_k == L + 2 && !m_own);
    chk("dm_ack", b.dm_ack, m_act && m_k == L + 2 && m_own);
    chk("if_rdata", b.if_rdata, m_ifr);
    chk("dm_rdata", b.dm_rdata, m_dmr);
    if (m_act) chk("grant", b.grant, m_own);
    if (m_act && m_k <= L + 1) begin
      chk("mem_addr", b.mem_addr, m_addr);
      if (m_we) chk("mem_wdata", b.mem_wdata, m_wd);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  int gseq[$];
  int acyc[$];
  bit t4_done;

  initial begin
    b.if_req = 0; b.if_addr = '0;
    b.dm_req = 0; b.dm_we = 0;
    b.dm_addr = '0; b.dm_wdata = '0;
    b2.if_req = 0; b2.if_addr = '0;
    b2.dm_req = 0; b2.dm_we = 0;
    b2.dm_addr = '0; b2.dm_wdata = '0;
    mem[64'h100] = 64'hDEADBEEF00000013;
    mem[64'h2000] = 64'hA5A5000011112222;
    repeat (3) step();
    chk("rst_if_ack", b.if_ack, 0);
    chk("rst_dm_ack", b.dm_ack, 0);
    chk("rst_if_rdata", b.if_rdata, 0);
    chk("rst_dm_rdata", b.dm_rdata, 0);
    chk("rst_mem_en", b.mem_en, 0);
    chk("rst_mem_addr", b.mem_addr, 0);
    chk("rst_mem_wdata", b.mem_wdata, 0);
    chk("rst_busy", b.busy, 0);
    chk("rst_grant", b.grant, 0);
    rst_n = 1;
    step();

    // simultaneous requests right after reset
    b.if_req = 1; b.if_addr = 64'h100;
    b.dm_req = 1; b.dm_we = 0; b.dm_addr = 64'h2000;
    for (int j = 1; j <= 9; j++) begin
      step();
      chk("t1_if_ack", b.if_ack, j == 4);
      chk("t1_dm_ack", b.dm_ack, j == 9);
      if (j == 1) begin
        chk("t1_grant0", b.grant, 0);
        chk("t1_en0", b.mem_en, 1);
        chk("t1_addr0", b.mem_addr, 64'h100);
      end
      if (j == 4) begin
        chk("t1_if_rdata", b.if_rdata, 64'hDEADBEEF00000013);
        b.if_req = 0;
      end
      if (j >= 6) chk("t1_grant1", b.grant, 1);
      if (j == 6) begin
        chk("t1_en1", b.mem_en, 1);
        chk("t1_addr1", b.mem_addr, 64'h2000);
      end
      if (j == 9) begin
        chk("t1_dm_rdata", b.dm_rdata, 64'hA5A5000011112222);
        b.dm_req = 0;
      end
    end
    step();

    // single fetch
    b.if_req = 1; b.if_addr = 64'h100;
    for (int j = 1; j <= 5; j++) begin
      step();
      chk("t2_busy", b.busy, j <= 4);
      chk("t2_if_ack", b.if_ack, j == 4);
      chk("t2_dm_ack", b.dm_ack, 0);
      if (j == 1) begin
        chk("t2_en", b.mem_en, 1);
        chk("t2_we", b.mem_we, 0);
        chk("t2_addr", b.mem_addr, 64'h100);
      end
      if (j == 4) begin
        chk("t2_rdata", b.if_rdata, 64'hDEADBEEF00000013);
        b.if_req = 0;
      end
    end

    // single store
    b.dm_req = 1; b.dm_we = 1;
    b.dm_addr = 64'h2008; b.dm_wdata = 64'h1234;
    for (int j = 1; j <= 5; j++) begin
      step();
      chk("t3_dm_ack", b.dm_ack, j == 4);
      if (j == 1) begin
        chk("t3_en", b.mem_en, 1);
        chk("t3_we", b.mem_we, 1);
        chk("t3_wdata", b.mem_wdata, 64'h1234);
      end
      if (j == 4) begin
        chk("t3_dm_rdata", b.dm_rdata, 64'hA5A5000011112222);
        b.dm_req = 0; b.dm_we = 0;
      end
    end
    chk("t3_mem", rd(64'h2008), 64'h1234);

    // round robin under continuous contention
    b.if_req = 1; b.if_addr = 64'h100;
    b.dm_req = 1; b.dm_we = 0; b.dm_addr = 64'h2000;
    t4_done = 0;
    for (int j = 0; j < 60 && !t4_done; j++) begin
      step();
      if (b.mem_en) gseq.push_back(int'(b.grant));
      if (b.if_ack && b.dm_ack) chk("t4_two_acks", 1, 0);
      if (b.if_ack || b.dm_ack) acyc.push_back(cyc);
      if (acyc.size() == 6) begin
        b.if_req = 0; b.dm_req = 0;
        t4_done = 1;
      end
    end
    chk("t4_done", t4_done, 1);
    chk("t4_ngrants", gseq.size(), 6);
    for (int i = 0; i < gseq.size() && i < 6; i++)
      chk("t4_grant", gseq[i], i % 2);
    for (int i = 1; i < acyc.size(); i++)
      chk("t4_spacing", acyc[i] - acyc[i-1], 5);
    step();

    // reset during a fetch
    b.if_req = 1; b.if_addr = 64'h100;
    step(); step();
    rst_n = 0; #1;
    chk("t5_en", b.mem_en, 0);
    chk("t5_busy", b.busy, 0);
    chk("t5_if_ack", b.if_ack, 0);
    chk("t5_if_rdata", b.if_rdata, 0);
    step(); step();
    rst_n = 1;
    chk("t5_rel_busy", b.busy, 0);
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("t5_en_after", b.mem_en, j == 1);
      chk("t5_ack_after", b.if_ack, j == 4);
      if (j == 4) begin
        chk("t5_rdata_after", b.if_rdata, 64'hDEADBEEF00000013);
        b.if_req = 0;
      end
    end
    step();

    // randomized traffic, with occasional reset pulses
    for (int j = 0; j < 3000; j++) begin
      step();
      rst_n = ($urandom_range(0, 499) != 0);
      b.if_req = ($urandom_range(0, 2) != 0);
      b.if_addr = 64'h1000 + 64'($urandom_range(0, 7)) * 8;
      b.dm_req = ($urandom_range(0, 2) != 0);
      b.dm_we = $urandom_range(0, 1) == 1;
      b.dm_addr = 64'h1000 + 64'($urandom_range(0, 7)) * 8;
      b.dm_wdata = {$urandom, $urandom};
    end
    rst_n = 1;
    b.if_req = 0; b.dm_req = 0;
    repeat (8) step();

    // latency-1 instance load
    b2.dm_req = 1; b2.dm_we = 0; b2.dm_addr = 64'h40;
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("t7_en", b2.mem_en, j == 1);
      chk("t7_dm_ack", b2.dm_ack, j == 3);
      chk("t7_if_ack", b2.if_ack, 0);
      if (j == 3) begin
        chk("t7_rdata", b2.dm_rdata, 64'h55);
        b2.dm_req = 0;
      end
    end
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
